// File: rtl/lpc_pkg.sv
// Shared widths, default parameters and FSM state type for the LPC autocorrelation block.
package lpc_pkg;

    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned ORDER_DEF     = 4;
    localparam int unsigned ACC_W_DEF     = 40;
    localparam int unsigned MAX_FRAME_DEF = 256;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_e;

endpackage

// File: rtl/lpc_mac_lane.sv
// One autocorrelation lag: signed x*d product, sign-extended and accumulated modulo 2^ACC_W.
module lpc_mac_lane
    import lpc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                       ACLK,
    input  logic                       ARESET_N,
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic signed [SAMPLE_W-1:0] d,
    input  logic                       clr,
    input  logic                       en,
    output logic signed [ACC_W-1:0]    acc_nxt_c
);

    localparam int unsigned PROD_W = 2 * SAMPLE_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod = x * d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Next value is exported so the top can load R[0] at the frame-end edge.
    assign acc_nxt_c = acc_d;

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/lpc_autocorr.sv
// Frame autocorrelation R[0..ORDER] over an input sample stream, emitted as an AXI-stream burst.
module lpc_autocorr
    import lpc_pkg::*;
#(
    parameter int unsigned ORDER     = ORDER_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned MAX_FRAME = MAX_FRAME_DEF
) (
    input  logic                ACLK,
    input  logic                ARESET_N,
    input  logic [SAMPLE_W-1:0] S_SAMPLE,
    input  logic                S_VALID,
    output logic                S_READY,
    input  logic                S_SAMPLE_LAST,
    input  logic                S_USER,
    output logic [ACC_W-1:0]    M_TDATA,
    output logic                M_TVALID,
    input  logic                M_TREADY,
    output logic                M_TLAST,
    output logic                M_TUSER
);

    localparam int unsigned IDX_W    = $clog2(ORDER + 1);
    localparam int unsigned CNT_W    = $clog2(MAX_FRAME);
    localparam int unsigned LAST_IDX = ORDER;
    localparam int unsigned LAST_CNT = MAX_FRAME - 1;

    state_e              state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tlast_q, m_tlast_d;
    logic                m_tuser_q, m_tuser_d;
    logic [ACC_W-1:0]    m_tdata_q, m_tdata_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] dly_q [ORDER];
    logic [SAMPLE_W-1:0] dly_d [ORDER];

    logic                    accept;
    logic                    lane_en;
    logic                    lane_clr;
    logic [SAMPLE_W-1:0]     lane_d   [ORDER+1];
    logic signed [ACC_W-1:0] lane_nxt [ORDER+1];

    assign accept = S_VALID & s_ready_q;

    // Lane 0 squares the sample; lane k pairs it with the sample k steps back.
    for (genvar k = 0; k <= ORDER; k++) begin : g_lane
        if (k == 0) begin : g_sq
            assign lane_d[k] = S_SAMPLE;
        end else begin : g_lag
            assign lane_d[k] = dly_q[k-1];
        end

        lpc_mac_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .ACLK      (ACLK),
            .ARESET_N  (ARESET_N),
            .x         (S_SAMPLE),
            .d         (lane_d[k]),
            .clr       (lane_clr),
            .en        (lane_en),
            .acc_nxt_c (lane_nxt[k])
        );
    end

    always_comb begin
        state_d    = state_q;
        s_ready_d  = s_ready_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        m_tdata_d  = m_tdata_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        lane_en    = 1'b0;
        lane_clr   = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (S_USER) begin
                        lane_clr = 1'b1;
                        cnt_d    = '0;
                        for (int i = 0; i < ORDER; i++) dly_d[i] = '0;
                    end else begin
                        lane_en  = 1'b1;
                        dly_d[0] = S_SAMPLE;
                        for (int i = 1; i < ORDER; i++) dly_d[i] = dly_q[i-1];
                        cnt_d = CNT_W'(cnt_q + 1'b1);
                        if (S_SAMPLE_LAST || (cnt_q == CNT_W'(LAST_CNT))) begin
                            state_d    = EMIT;
                            s_ready_d  = 1'b0;
                            m_tvalid_d = 1'b1;
                            idx_d      = '0;
                            m_tuser_d  = 1'b1;
                            m_tlast_d  = 1'b0;
                            m_tdata_d  = lane_nxt[0];
                        end
                    end
                end
            end
            EMIT: begin
                if (M_TREADY) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d    = ACCUM;
                        s_ready_d  = 1'b1;
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        m_tuser_d  = 1'b0;
                        m_tdata_d  = '0;
                        idx_d      = '0;
                        cnt_d      = '0;
                        lane_clr   = 1'b1;
                        for (int i = 0; i < ORDER; i++) dly_d[i] = '0;
                    end else begin
                        idx_d     = IDX_W'(idx_q + 1'b1);
                        m_tdata_d = lane_nxt[idx_d];
                        m_tlast_d = (idx_d == IDX_W'(LAST_IDX));
                        m_tuser_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state_q    <= ACCUM;
            s_ready_q  <= 1'b1;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            m_tdata_q  <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < ORDER; i++) dly_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
            m_tdata_q  <= m_tdata_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < ORDER; i++) dly_q[i] <= dly_d[i];
        end
    end

    assign S_READY  = s_ready_q;
    assign M_TVALID = m_tvalid_q;
    assign M_TLAST  = m_tlast_q;
    assign M_TUSER  = m_tuser_q;
    assign M_TDATA  = m_tdata_q;

endmodule

// File: tb/tb_lpc_autocorr.sv
// Scoreboard bench for lpc_autocorr: directed frames plus random frames against a lag-sum model.
module tb_lpc_autocorr;

    localparam int unsigned ORDER     = 4;
    localparam int unsigned ACC_W     = 40;
    localparam int unsigned MAX_FRAME = 256;

    logic             ACLK = 1'b0;
    logic             ARESET_N = 1'b0;
    logic [15:0]      S_SAMPLE = '0;
    logic             S_VALID = 1'b0;
    logic             S_READY;
    logic             S_SAMPLE_LAST = 1'b0;
    logic             S_USER = 1'b0;
    logic [ACC_W-1:0] M_TDATA;
    logic             M_TVALID;
    logic             M_TREADY = 1'b1;
    logic             M_TLAST;
    logic             M_TUSER;

    lpc_autocorr #(.ORDER(ORDER), .ACC_W(ACC_W), .MAX_FRAME(MAX_FRAME)) dut (
        .ACLK          (ACLK),
        .ARESET_N      (ARESET_N),
        .S_SAMPLE      (S_SAMPLE),
        .S_VALID       (S_VALID),
        .S_READY       (S_READY),
        .S_SAMPLE_LAST (S_SAMPLE_LAST),
        .S_USER        (S_USER),
        .M_TDATA       (M_TDATA),
        .M_TVALID      (M_TVALID),
        .M_TREADY      (M_TREADY),
        .M_TLAST       (M_TLAST),
        .M_TUSER       (M_TUSER)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [ACC_W-1:0] d;
        logic             l;
        logic             u;
    } exp_t;

    exp_t    sb[$];
    shortint frame[$];
    int      tests = 0;
    int      fails = 0;
    int      pops = 0;
    int      ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit      model_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic exp5(input longint a, input longint b, input longint c, input longint d, input longint e);
        longint v[5];
        v = '{a, b, c, d, e};
        for (int k = 0; k <= ORDER; k++) begin
            exp_t x;
            x.d = v[k][ACC_W-1:0];
            x.l = (k == ORDER);
            x.u = (k == 0);
            sb.push_back(x);
        end
    endtask

    // Reference: R[k] = sum over n of x[n]*x[n-k], zero outside the frame.
    task automatic model_frame_end();
        for (int k = 0; k <= ORDER; k++) begin
            longint s = 0;
            exp_t   x;
            for (int n = k; n < frame.size(); n++) s += longint'(frame[n]) * longint'(frame[n-k]);
            x.d = s[ACC_W-1:0];
            x.l = (k == ORDER);
            x.u = (k == 0);
            sb.push_back(x);
        end
        frame.delete();
    endtask

    task automatic model_accept(input logic [15:0] x, input logic last, input logic user);
        if (user) begin
            frame.delete();
        end else begin
            frame.push_back(shortint'(x));
            if (last || frame.size() == MAX_FRAME) model_frame_end();
        end
    endtask

    // Called in the low clock phase; returns at the negedge after acceptance.
    task automatic send(input logic [15:0] x, input logic last, input logic user);
        int t = 0;
        S_SAMPLE      = x;
        S_SAMPLE_LAST = last;
        S_USER        = user;
        S_VALID       = 1'b1;
        while (!S_READY && t < 1000) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 1000) begin
            check("send_timeout", 64'(t), 64'(0));
        end else begin
            @(posedge ACLK);
            if (model_en) model_accept(x, last, user);
            @(negedge ACLK);
        end
        S_VALID = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || M_TVALID) && t < 2000) begin
            @(negedge ACLK);
            #1;
            t++;
        end
        check("drain_timeout", 64'(t >= 2000), 64'(0));
        check("ready_after_burst", 64'(S_READY), 64'(1));
    endtask

    always @(posedge ACLK) begin
        #1;
        case (ready_mode)
            0:       M_TREADY = 1'b1;
            2:       M_TREADY = 1'b0;
            default: M_TREADY = ($urandom % 4) != 0;
        endcase
    end

    // Monitor: every output handshake pops one expected lag; stalls must hold the bus.
    logic             stall_prev = 1'b0;
    logic [ACC_W-1:0] prev_data;
    logic             prev_last;
    logic             prev_user;
    always @(negedge ACLK) begin
        if (!ARESET_N) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && M_TVALID) begin
                check("hold_data", 64'(M_TDATA), 64'(prev_data));
                check("hold_flags", 64'({M_TLAST, M_TUSER}), 64'({prev_last, prev_user}));
            end
            if (M_TVALID && M_TREADY) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h, required none", M_TDATA);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("lag_data", 64'(M_TDATA), 64'(e.d));
                    check("lag_last", 64'(M_TLAST), 64'(e.l));
                    check("lag_user", 64'(M_TUSER), 64'(e.u));
                end
                pops++;
            end
            stall_prev = M_TVALID && !M_TREADY;
            prev_data  = M_TDATA;
            prev_last  = M_TLAST;
            prev_user  = M_TUSER;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        repeat (3) @(negedge ACLK);
        check("rst_s_ready", 64'(S_READY), 64'(1));
        check("rst_m_tvalid", 64'(M_TVALID), 64'(0));
        check("rst_flags", 64'({M_TLAST, M_TUSER}), 64'(0));
        check("rst_m_tdata", 64'(M_TDATA), 64'(0));
        ARESET_N = 1'b1;
        @(negedge ACLK);

        // Basic 3-sample frame, output visible the cycle after the last sample.
        exp5(14, 8, 3, 0, 0);
        send(16'd1, 1'b0, 1'b0);
        send(16'd2, 1'b0, 1'b0);
        send(16'd3, 1'b1, 1'b0);
        check("latency_valid", 64'(M_TVALID), 64'(1));
        check("latency_r0", 64'(M_TDATA), 64'(14));
        check("latency_user", 64'(M_TUSER), 64'(1));
        check("emit_not_ready", 64'(S_READY), 64'(0));
        drain();

        // Most-negative samples.
        exp5(64'h0080000000, 64'h0040000000, 0, 0, 0);
        send(16'h8000, 1'b0, 1'b0);
        send(16'h8000, 1'b1, 1'b0);
        drain();

        // Output stall holds R[0] and keeps input blocked.
        ready_mode = 2;
        exp5(14, 8, 3, 0, 0);
        send(16'd1, 1'b0, 1'b0);
        send(16'd2, 1'b0, 1'b0);
        send(16'd3, 1'b1, 1'b0);
        repeat (5) begin
            check("stall_data", 64'(M_TDATA), 64'(14));
            check("stall_s_ready", 64'(S_READY), 64'(0));
            S_VALID = 1'b1;
            @(negedge ACLK);
        end
        S_VALID = 1'b0;
        ready_mode = 0;
        drain();

        // Flush discards the partial frame; its last flag is ignored.
        exp5(1, 0, 0, 0, 0);
        send(16'd5, 1'b0, 1'b0);
        send(16'd5, 1'b0, 1'b0);
        send(16'd7, 1'b1, 1'b1);
        send(16'd1, 1'b1, 1'b0);
        drain();

        // Forced frame end at MAX_FRAME samples.
        exp5(256, 255, 254, 253, 252);
        for (int i = 0; i < MAX_FRAME; i++) send(16'd1, 1'b0, 1'b0);
        check("forced_emit", 64'(M_TVALID), 64'(1));
        drain();
        exp5(4, 0, 0, 0, 0);
        send(16'd2, 1'b1, 1'b0);
        drain();

        // Reset while R[2] is on the bus.
        exp5(14, 8, 3, 0, 0);
        base = pops;
        send(16'd1, 1'b0, 1'b0);
        send(16'd2, 1'b0, 1'b0);
        send(16'd3, 1'b1, 1'b0);
        t = 0;
        while (pops < base + 2 && t < 100) begin
            @(negedge ACLK);
            #1;
            t++;
        end
        check("reset_wait_timeout", 64'(t >= 100), 64'(0));
        @(posedge ACLK);
        #2;
        check("r2_on_bus", 64'(M_TDATA), 64'(3));
        ARESET_N = 1'b0;
        #1;
        check("async_rst_valid", 64'(M_TVALID), 64'(0));
        check("async_rst_ready", 64'(S_READY), 64'(1));
        check("async_rst_data", 64'(M_TDATA), 64'(0));
        sb.delete();
        @(negedge ACLK);
        ARESET_N = 1'b1;
        @(negedge ACLK);
        check("post_rst_valid", 64'(M_TVALID), 64'(0));
        check("post_rst_ready", 64'(S_READY), 64'(1));
        exp5(9, 0, 0, 0, 0);
        send(16'd3, 1'b1, 1'b0);
        drain();

        // Random frames, random gaps, random backpressure, occasional flush.
        model_en = 1'b1;
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++) begin
                logic [15:0] x;
                if ($urandom % 20 == 0) send(16'($urandom), 1'($urandom), 1'b1);
                x = ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
                send(x, (i == len - 1), 1'b0);
                if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge ACLK);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lpc_autocorr.md
# lpc_autocorr

Downstream consumer of the AXI-stream sample slave in the LPC encoder. Accepts 16-bit signed samples over a valid/ready handshake and accumulates autocorrelation lags R[0..ORDER] across one frame. A frame ends on a flagged last sample or when the frame length limit is reached. The block then streams the ORDER+1 lag values over an AXI-stream master to the Levinson-Durbin stage, stalling input until the last lag is taken.

## Interface
Parameters:
- ORDER, 4: highest lag computed; ORDER+1 lags are emitted.
- ACC_W, 40: accumulator and output width, signed.
- MAX_FRAME, 256: samples per frame before a forced frame end.

Ports:
- ACLK  in  1  clock; all logic is rising-edge.
- ARESET_N  in  1  reset, asynchronous, active-low.
- S_SAMPLE  in  16  signed input sample.
- S_VALID  in  1  S_SAMPLE is valid.
- S_READY  out  1  block accepts a sample; registered.
- S_SAMPLE_LAST  in  1  sample is the last of its frame.
- S_USER  in  1  flush request; the accompanying sample is discarded.
- M_TDATA  out  ACC_W  lag value R[idx].
- M_TVALID  out  1  M_TDATA is valid; registered.
- M_TREADY  in  1  downstream accepts.
- M_TLAST  out  1  high on R[ORDER].
- M_TUSER  out  1  high on R[0], marking the frame start.

## Operation
- A sample is accepted when S_VALID & S_READY are both high at a rising edge.
- States: ACCUM and EMIT.
- Reset values:
  - state ACCUM, S_READY=1.
  - accumulators, delay line, frame count and idx all 0.
  - M_TVALID=0, M_TLAST=0, M_TUSER=0, M_TDATA=0.
- ACCUM, on acceptance with S_USER=0:
  - R[0] += x·x.
  - R[k] += x·d[k-1] for k=1..ORDER, where d[0] is the previous sample of the frame.
  - Then shift x into the delay line and increment the frame count.
- Products are full 32-bit signed and sign-extended to ACC_W. Accumulation is modular (2^ACC_W), exact for MAX_FRAME ≤ 256.
- Delay line starts at zero each frame, giving the windowed autocorrelation method with zero padding.
- ACCUM to EMIT: on an accepted sample with S_SAMPLE_LAST=1, or with frame count == MAX_FRAME-1.
  - At that same edge: S_READY←0, M_TVALID←1, idx←0.
- EMIT:
  - M_TDATA = R[idx].
  - M_TLAST = (idx == ORDER).
  - M_TUSER = (idx == 0).
  - idx increments on each M_TVALID & M_TREADY.
- EMIT to ACCUM: on the handshake with idx == ORDER.
  - At that edge: M_TVALID←0; accumulators, delay line, count and idx cleared; S_READY←1.
- Flush: an accepted sample with S_USER=1, in ACCUM, clears the accumulators, delay line and count and stays in ACCUM. S_SAMPLE_LAST is ignored on that sample.
- S_USER is never seen in EMIT because S_READY=0 there.
- An empty frame cannot occur, since a frame end always carries a sample.

## Timing
- Throughput: one sample per cycle in ACCUM; S_READY stays high through back-to-back accepts.
- Latency: R[0] is valid on M_TDATA in the first cycle after the final sample is accepted.
- Emit duration: minimum ORDER+1 cycles with M_TREADY tied high.
- Input dead time per frame: ORDER+1 cycles minimum, plus any output stall cycles.
- Backpressure: while M_TVALID=1 and M_TREADY=0, M_TDATA, M_TLAST, M_TUSER and idx hold stable.
- S_READY returns to 1 in the cycle after the final lag handshake.
- S_VALID may rise or fall freely; an S_VALID pulse while S_READY=0 has no effect.
- Reset mid-frame or mid-emit: all outputs return to their reset values immediately (asynchronous reset). The partial frame is lost and no partial burst is completed.

## Structure
- lpc_pkg holds:
  - SAMPLE_W=16, default ORDER and ACC_W, MAX_FRAME.
  - state enum {ACCUM, EMIT}.
- Sub-module lpc_mac_lane: one multiply-accumulate lane (operands x and d, clear, enable, ACC_W accumulator). It is instantiated ORDER+1 times; lane 0 takes x for both operands.
- Top level holds the FSM, delay line, frame counter, idx and output mux.

## Test plan
- Frame 1, 2, 3 (last on 3), ORDER=4, M_TREADY=1 -> M_TDATA 14, 8, 3, 0, 0 on 5 consecutive cycles; M_TUSER on 14, M_TLAST on the final 0.
- Frame -32768, -32768 (last) -> R0 = 0x0080000000, R1 = 0x0040000000, R2..R4 = 0; no overflow or sign error.
- Same 3-sample frame, M_TREADY low 5 cycles after M_TVALID rises -> M_TDATA holds 14, S_READY holds 0; the sequence then completes unchanged.
- Samples 5, 5, then 7 with S_USER=1, then 1 with last -> lags 1, 0, 0, 0, 0.
- 256 samples of 1, no last -> forced emit of 256, 255, 254, 253, 252. The 257th sample opens a new frame; a single value 2 with last then yields 4, 0, 0, 0, 0.
- ARESET_N pulsed low during emit of R[2] -> M_TVALID=0 and S_READY=1 after release. Next frame 3 (last) yields 9, 0, 0, 0, 0.
